zx8x_tape_player: RTL and testbench
===================================

Name: zx8x_tape_player

Overview:
- Generates a ZX80/ZX81-format cassette waveform from the tape buffer. This is the transmit end of the EAR path that the machine's LOAD routine reads.
- Reads bytes from the synchronous tape RAM and emits pulse trains on `tape_out`. The top level ORs `tape_out` into the CPU's `tape_in` bit, so unpatched ROM LOAD, turbo-less loaders and custom loaders work.
- Optionally prepends a one-byte program name, because .p files carry no name.

Parameters:
- PULSE_CYC, 7800, clk_sys cycles per pulse half (150 us high, then 150 us low, at 52 MHz)
- GAP_CYC, 67600, silence after each bit (1300 us)
- LEAD_CYC, 26000000, silence before the first byte (0.5 s)
- ADDR_W, 14, tape buffer address width

Ports:
- clk_sys  in  1  system clock
- reset_n  in  1  asynchronous reset, active low
- start  in  1  one-cycle pulse; begins playback when idle
- stop  in  1  one-cycle pulse; aborts playback
- pause  in  1  level; freezes all timers and holds `tape_out` low while high
- add_name  in  1  sampled at start; 1 = emit name byte 8'h80 before buffer data
- length  in  ADDR_W  number of bytes in buffer; sampled at start
- mem_addr  out  ADDR_W  tape RAM read address
- mem_data  in  8  tape RAM data; valid 1 cycle after `mem_addr` changes
- tape_out  out  1  waveform, 1 = pulse high
- busy  out  1  high from accepted start until DONE/abort
- done  out  1  one-cycle pulse when the last bit's gap completes

Behaviour:
- Reset values: `tape_out`=0, `busy`=0, `done`=0, `mem_addr`=0, state=IDLE, all counters 0.
- Bit encoding: each byte is sent MSB first.
  - Bit 0 = 4 pulses; bit 1 = 9 pulses.
  - Each pulse = PULSE_CYC cycles high, then PULSE_CYC cycles low.
  - After the last pulse of every bit, `tape_out` stays low for GAP_CYC cycles.
- States:
  - IDLE: `start` -> LEAD. Latch `length` and `add_name`, set `busy`=1, set `mem_addr`=0, clear byte index.
  - LEAD: low for LEAD_CYC cycles, then:
    - if `add_name`: load shift register with 8'h80 -> BIT;
    - else if `length`==0: -> DONE;
    - else -> FETCH.
  - FETCH: present `mem_addr`=index, wait one cycle, -> LOAD.
  - LOAD: capture `mem_data` into the 8-bit shift register, set bit count=8 -> BIT.
  - BIT: pulse count = 9 if shift_reg[7] else 4 -> HI.
  - HI: `tape_out`=1 for PULSE_CYC cycles -> LO.
  - LO: `tape_out`=0 for PULSE_CYC cycles. Decrement pulse count; if it is now 0 -> GAP, else -> HI.
  - GAP: low for GAP_CYC cycles. Shift left and decrement bit count; if bits remain -> BIT. Otherwise, for the byte just sent:
    - if it was the name byte: `length`==0 -> DONE, else -> FETCH at index 0;
    - else increment index; index==`length` -> DONE, else -> FETCH.
  - DONE: `done`=1 for one cycle, `busy`=0 -> IDLE.
- Timer: a single down-counter, wide enough for LEAD_CYC (25 bits at default).
  - Each phase lasts exactly the parameter count. The first high cycle of HI is the cycle after entry into HI.
- Byte duration check: bit 0 = 8·PULSE_CYC + GAP_CYC cycles; bit 1 = 18·PULSE_CYC + GAP_CYC cycles. FETCH/LOAD/BIT overhead between bits or bytes is at most 3 cycles and is fixed (deterministic).
- `start` while `busy`: ignored.
- `stop`: from any state -> IDLE next cycle. `tape_out`=0, `busy`=0, no `done`.
- `stop` and `start` in the same cycle: `stop` wins.
- `pause`: the timer and state hold. `tape_out` is forced to 0 and `busy` stays 1. On release, the interrupted phase resumes with its remaining count.
- Index arithmetic: ADDR_W bits. `length`==0 with `add_name` emits only the name.
- Asynchronous reset mid-playback returns all outputs to reset values immediately.

Test Plan:
Bench parameters for all scenarios: PULSE_CYC=4, GAP_CYC=10, LEAD_CYC=20.
- Single byte: `length`=1, buf[0]=8'hA5, `add_name`=0, start.
  -> 20 low cycles, then bit sequence 1,0,1,0,0,1,0,1 giving pulse counts 9,4,9,4,4,9,4,9.
  -> Each pulse is 4 high + 4 low, and each bit is followed by 10 low.
  -> `done` pulses once; total cycles = 20 + 52·8 + 10·8 + bounded fetch overhead; `busy` drops with `done`.
- Name prepend: `add_name`=1, `length`=2, buf=8'h00, 8'hFF.
  -> First byte is 8'h80 (one bit with 9 pulses, then seven bits with 4 pulses), then 8 bits with 4 pulses, then 8 bits with 9 pulses.
  -> `mem_addr` visits 0 then 1.
- Zero length: `length`=0, `add_name`=0.
  -> 20 low cycles, `done` pulse, `tape_out` never high.
  -> With `add_name`=1, exactly the 8'h80 pattern is emitted.
- Abort: `stop` during the third HI of byte 0.
  -> Next cycle `tape_out`=0, `busy`=0, no `done`.
  -> A new `start` restarts from the leader with `mem_addr`=0.
- Pause: assert `pause` for 7 cycles in the middle of a GAP.
  -> `tape_out` is 0 during the pause; the total run is exactly 7 cycles longer than the unpaused run.
  -> A `start` pulse asserted during play is ignored (one `done` only).
- Reset: drop `reset_n` mid-pulse with `tape_out`=1.
  -> `tape_out`, `busy` and `done` read 0 before the next clk_sys edge.

Source files
------------

// File: rtl/zx8x_tape_player.sv
// rtl/zx8x_tape_player.sv - ZX80/ZX81 cassette waveform generator fed from the tape buffer RAM.
// Bytes go out MSB first as 4 (bit 0) or 9 (bit 1) pulses, each bit followed by a silent gap.
module zx8x_tape_player #(
    parameter int PULSE_CYC = 7800,
    parameter int GAP_CYC   = 67600,
    parameter int LEAD_CYC  = 26000000,
    parameter int ADDR_W    = 14
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              start,
    input  logic              stop,
    input  logic              pause,
    input  logic              add_name,
    input  logic [ADDR_W-1:0] length,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_data,
    output logic              tape_out,
    output logic              busy,
    output logic              done
);

    localparam int MAX_CYC = (LEAD_CYC > GAP_CYC)
                           ? ((LEAD_CYC > PULSE_CYC) ? LEAD_CYC : PULSE_CYC)
                           : ((GAP_CYC > PULSE_CYC) ? GAP_CYC : PULSE_CYC);
    localparam int TMR_W = $clog2(MAX_CYC + 1);

    // Timer is loaded with count-1 on phase entry so each phase spans exactly its count.
    localparam logic [TMR_W-1:0] PULSE_LD = TMR_W'(PULSE_CYC - 1);
    localparam logic [TMR_W-1:0] GAP_LD   = TMR_W'(GAP_CYC - 1);
    localparam logic [TMR_W-1:0] LEAD_LD  = TMR_W'(LEAD_CYC - 1);

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_LEAD  = 4'd1,
        S_FETCH = 4'd2,
        S_LOAD  = 4'd3,
        S_BIT   = 4'd4,
        S_HI    = 4'd5,
        S_LO    = 4'd6,
        S_GAP   = 4'd7,
        S_DONE  = 4'd8
    } state_t;

    state_t            state_q, state_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic [7:0]        shift_q, shift_d;
    logic [3:0]        bit_cnt_q, bit_cnt_d;
    logic [3:0]        pulse_cnt_q, pulse_cnt_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [ADDR_W-1:0] len_q, len_d;
    logic              name_en_q, name_en_d;
    logic              is_name_q, is_name_d;

    logic              hold;
    logic              tmr_zero;
    logic [ADDR_W-1:0] idx_inc;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            timer_q     <= '0;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            pulse_cnt_q <= '0;
            idx_q       <= '0;
            len_q       <= '0;
            name_en_q   <= 1'b0;
            is_name_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            pulse_cnt_q <= pulse_cnt_d;
            idx_q       <= idx_d;
            len_q       <= len_d;
            name_en_q   <= name_en_d;
            is_name_q   <= is_name_d;
        end
    end

    // DONE is excluded from the freeze so the done pulse always stays one cycle wide.
    assign hold     = pause && (state_q != S_IDLE) && (state_q != S_DONE);
    assign tmr_zero = (timer_q == '0);
    assign idx_inc  = idx_q + ADDR_W'(1);

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        pulse_cnt_d = pulse_cnt_q;
        idx_d       = idx_q;
        len_d       = len_q;
        name_en_d   = name_en_q;
        is_name_d   = is_name_q;

        if (stop) begin
            state_d = S_IDLE;
        end else if (!hold) begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_d   = S_LEAD;
                        timer_d   = LEAD_LD;
                        len_d     = length;
                        name_en_d = add_name;
                        idx_d     = '0;
                    end
                end
                S_LEAD: begin
                    if (!tmr_zero) begin
                        timer_d = timer_q - TMR_W'(1);
                    end else if (name_en_q) begin
                        shift_d   = 8'h80;
                        bit_cnt_d = 4'd8;
                        is_name_d = 1'b1;
                        state_d   = S_BIT;
                    end else if (len_q == '0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_FETCH;
                    end
                end
                S_FETCH: begin
                    state_d = S_LOAD;
                end
                S_LOAD: begin
                    shift_d   = mem_data;
                    bit_cnt_d = 4'd8;
                    is_name_d = 1'b0;
                    state_d   = S_BIT;
                end
                S_BIT: begin
                    pulse_cnt_d = shift_q[7] ? 4'd9 : 4'd4;
                    timer_d     = PULSE_LD;
                    state_d     = S_HI;
                end
                S_HI: begin
                    if (!tmr_zero) begin
                        timer_d = timer_q - TMR_W'(1);
                    end else begin
                        timer_d = PULSE_LD;
                        state_d = S_LO;
                    end
                end
                S_LO: begin
                    if (!tmr_zero) begin
                        timer_d = timer_q - TMR_W'(1);
                    end else begin
                        pulse_cnt_d = pulse_cnt_q - 4'd1;
                        if (pulse_cnt_q == 4'd1) begin
                            timer_d = GAP_LD;
                            state_d = S_GAP;
                        end else begin
                            timer_d = PULSE_LD;
                            state_d = S_HI;
                        end
                    end
                end
                S_GAP: begin
                    if (!tmr_zero) begin
                        timer_d = timer_q - TMR_W'(1);
                    end else begin
                        shift_d   = {shift_q[6:0], 1'b0};
                        bit_cnt_d = bit_cnt_q - 4'd1;
                        if (bit_cnt_q != 4'd1) begin
                            state_d = S_BIT;
                        end else if (is_name_q) begin
                            // Name byte consumed no buffer slot; data still starts at index 0.
                            state_d = (len_q == '0) ? S_DONE : S_FETCH;
                        end else if (idx_inc == len_q) begin
                            state_d = S_DONE;
                        end else begin
                            idx_d   = idx_inc;
                            state_d = S_FETCH;
                        end
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        tape_out = (state_q == S_HI) && !pause;
        busy     = (state_q != S_IDLE) && (state_q != S_DONE);
        done     = (state_q == S_DONE);
        mem_addr = idx_q;
    end

endmodule

// File: tb/tb_zx8x_tape_player.sv
// tb/tb_zx8x_tape_player.sv - self-checking bench for zx8x_tape_player.
// Expected waveform is built from a per-bit pulse list and compared cycle by cycle.
module tb_zx8x_tape_player;

    localparam int PC = 4;
    localparam int GC = 10;
    localparam int LC = 20;
    localparam int AW = 14;

    logic          clk_sys = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          pause = 1'b0;
    logic          add_name = 1'b0;
    logic [AW-1:0] length = '0;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_data;
    logic          tape_out;
    logic          busy;
    logic          done;

    logic [7:0] mem [0:(1<<AW)-1];

    int total = 0;
    int bad   = 0;

    // Each element: {busy, done, tape_out} expected in one sampled cycle.
    logic [2:0] exp_q[$];

    typedef struct {
        int         len;
        bit         nm;
        logic [7:0] b0;
        logic [7:0] b1;
        int         cyc;
        int         pulses;
        int         maxaddr;
    } vec_t;

    vec_t tbl[4];

    zx8x_tape_player #(
        .PULSE_CYC(PC),
        .GAP_CYC  (GC),
        .LEAD_CYC (LC),
        .ADDR_W   (AW)
    ) dut (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .start   (start),
        .stop    (stop),
        .pause   (pause),
        .add_name(add_name),
        .length  (length),
        .mem_addr(mem_addr),
        .mem_data(mem_data),
        .tape_out(tape_out),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk_sys = ~clk_sys;

    always @(posedge clk_sys) mem_data <= mem[mem_addr];

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_sys);
        #1;
    endtask

    function automatic void build(input int len, input bit nm);
        logic [7:0] by[$];
        exp_q.delete();
        repeat (LC) exp_q.push_back(3'b100);
        if (nm) by.push_back(8'h80);
        for (int i = 0; i < len; i++) by.push_back(mem[i]);
        for (int j = 0; j < by.size(); j++) begin
            if (!(nm && j == 0)) repeat (2) exp_q.push_back(3'b100);
            for (int b = 7; b >= 0; b--) begin
                exp_q.push_back(3'b100);
                repeat (by[j][b] ? 9 : 4) begin
                    repeat (PC) exp_q.push_back(3'b101);
                    repeat (PC) exp_q.push_back(3'b100);
                end
                repeat (GC) exp_q.push_back(3'b100);
            end
        end
        exp_q.push_back(3'b010);
        repeat (5) exp_q.push_back(3'b000);
    endfunction

    task automatic play(input string nm, input int len, input bit name,
                        input int pause_at, input int pause_len, input int restart_at,
                        output int cyc_busy, output int pulses, output int dones,
                        output int maxaddr);
        int         k;
        int         n;
        int         first;
        bit         prev;
        logic [2:0] e;
        cyc_busy = 0; pulses = 0; dones = 0; maxaddr = 0;
        build(len, name);
        length   = AW'(len);
        add_name = name;
        start    = 1'b1;
        cyc();
        start = 1'b0;
        k = 0; n = 0; first = -1; prev = 1'b0;
        while (k < exp_q.size() && n < 20000) begin
            pause = (n >= pause_at) && (n < pause_at + pause_len);
            start = (n == restart_at);
            @(negedge clk_sys);
            e = pause ? 3'b100 : exp_q[k];
            if (first < 0 && ({busy, done, tape_out} !== e || (n == 0 && mem_addr !== '0)))
                first = n;
            if (busy) cyc_busy++;
            if (done) dones++;
            if (tape_out && !prev) pulses++;
            prev = tape_out;
            if (busy && int'(mem_addr) > maxaddr) maxaddr = int'(mem_addr);
            if (!pause) k++;
            n++;
            cyc();
        end
        pause = 1'b0;
        start = 1'b0;
        chk({nm, " wave_first_bad_cycle"}, first, -1);
        chk({nm, " model_consumed"}, k, exp_q.size());
    endtask

    initial begin
        int cb, pu, dn, ma;

        tbl[0] = '{len: 1, nm: 1'b0, b0: 8'hA5, b1: 8'h00, cyc: 526,  pulses: 52,  maxaddr: 0};
        tbl[1] = '{len: 2, nm: 1'b1, b0: 8'h00, b1: 8'hFF, cyc: 1416, pulses: 141, maxaddr: 1};
        tbl[2] = '{len: 0, nm: 1'b0, b0: 8'h00, b1: 8'h00, cyc: 20,   pulses: 0,   maxaddr: 0};
        tbl[3] = '{len: 0, nm: 1'b1, b0: 8'h00, b1: 8'h00, cyc: 404,  pulses: 37,  maxaddr: 0};

        repeat (3) @(posedge clk_sys);
        @(negedge clk_sys);
        chk("reset tape_out", int'(tape_out), 0);
        chk("reset busy", int'(busy), 0);
        chk("reset done", int'(done), 0);
        chk("reset mem_addr", int'(mem_addr), 0);
        @(posedge clk_sys);
        #1 reset_n = 1'b1;
        cyc();

        for (int t = 0; t < 4; t++) begin
            mem[0] = tbl[t].b0;
            mem[1] = tbl[t].b1;
            play($sformatf("vec%0d", t), tbl[t].len, tbl[t].nm, -1, 0, -1, cb, pu, dn, ma);
            chk($sformatf("vec%0d busy_cycles", t), cb, tbl[t].cyc);
            chk($sformatf("vec%0d pulses", t), pu, tbl[t].pulses);
            chk($sformatf("vec%0d done_count", t), dn, 1);
            chk($sformatf("vec%0d max_addr", t), ma, tbl[t].maxaddr);
        end

        // Abort during the third high phase of byte 0 (cycle 40 after start).
        mem[0] = 8'hA5;
        length = AW'(1);
        add_name = 1'b0;
        start = 1'b1;
        cyc();
        start = 1'b0;
        for (int n = 0; n < 40; n++) cyc();
        @(negedge clk_sys);
        chk("abort pre tape_out", int'(tape_out), 1);
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        @(negedge clk_sys);
        chk("abort tape_out", int'(tape_out), 0);
        chk("abort busy", int'(busy), 0);
        chk("abort done", int'(done), 0);
        dn = 0;
        for (int n = 0; n < 30; n++) begin
            cyc();
            @(negedge clk_sys);
            if (done || busy || tape_out) dn++;
        end
        chk("abort stays idle", dn, 0);
        play("restart", 1, 1'b0, -1, 0, -1, cb, pu, dn, ma);
        chk("restart done_count", dn, 1);

        // Pause inside the first gap plus an ignored start mid-play.
        play("pause", 1, 1'b0, 100, 7, 50, cb, pu, dn, ma);
        chk("pause busy_cycles", cb, 526 + 7);
        chk("pause done_count", dn, 1);
        chk("pause pulses", pu, 52);

        for (int r = 0; r < 6; r++) begin
            int  len;
            bit  nm;
            len = $urandom_range(0, 3);
            nm  = 1'($urandom_range(0, 1));
            for (int i = 0; i < len; i++) mem[i] = 8'($urandom);
            play($sformatf("rand%0d", r), len, nm, -1, 0, -1, cb, pu, dn, ma);
            chk($sformatf("rand%0d done_count", r), dn, 1);
        end

        // Asynchronous reset while a pulse is high (cycle 24 is inside the first HI).
        mem[0] = 8'hA5;
        length = AW'(1);
        add_name = 1'b0;
        start = 1'b1;
        cyc();
        start = 1'b0;
        for (int n = 0; n < 24; n++) cyc();
        @(negedge clk_sys);
        chk("rst pre tape_out", int'(tape_out), 1);
        #2 reset_n = 1'b0;
        #1;
        chk("rst tape_out", int'(tape_out), 0);
        chk("rst busy", int'(busy), 0);
        chk("rst done", int'(done), 0);
        chk("rst mem_addr", int'(mem_addr), 0);
        cyc();
        reset_n = 1'b1;
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
